// File: rtl/sram_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the multi-bank asynchronous SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_RECOV,
    ST_DONE
  } state_t;

  localparam int CNT_W = 4;

  // Bank-select field width; a single bank still reserves one bit so an out-of-range index exists.
  function automatic int bank_sel_w(input int num_banks);
    return (num_banks <= 2) ? 1 : $clog2(num_banks);
  endfunction

  function automatic bit cfg_ok(input int data_w, input int num_banks, input int bank_aw,
                                input int read_wait, input int write_width,
                                input int write_recovery);
    return (data_w >= 8) && (data_w % 8 == 0) &&
           (num_banks >= 1) && (num_banks <= 8) && (bank_aw >= 1) &&
           (read_wait >= 0) && (read_wait <= 15) &&
           (write_width >= 1) && (write_width <= 15) &&
           (write_recovery >= 0) && (write_recovery <= 15);
  endfunction

endpackage

// File: rtl/sram_byte_merge.sv
// Byte-granular merge of write data over read data, used to complete partial-byte writes.
module sram_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   rd_word,
  input  logic [DATA_W-1:0]   wr_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (be[i]) merged[8*i +: 8] = wr_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// Multi-bank asynchronous SRAM controller: one request at a time, programmable strobe timing,
// byte-enable writes completed by an internal read-modify-write.
module sram_bank_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int NUM_BANKS      = 2,
  parameter int BANK_AW        = 20,
  parameter int READ_WAIT      = 0,
  parameter int WRITE_WIDTH    = 1,
  parameter int WRITE_RECOVERY = 1
) (
  input  logic                                     clk50M,
  input  logic                                     rst,
  input  logic                                     req,
  input  logic                                     we,
  input  logic [DATA_W/8-1:0]                      be,
  input  logic [BANK_AW+bank_sel_w(NUM_BANKS)-1:0] addr,
  input  logic [DATA_W-1:0]                        wdata,
  output logic [DATA_W-1:0]                        rdata,
  output logic                                     ack,
  output logic                                     err,
  output logic                                     busy,
  output logic [BANK_AW-1:0]                       sram_addr,
  output logic [NUM_BANKS-1:0]                     sram_ce_n,
  output logic                                     sram_oe_n,
  output logic                                     sram_we_n,
  output logic [NUM_BANKS*DATA_W-1:0]              sram_dq_o,
  output logic [NUM_BANKS-1:0]                     sram_dq_oe,
  input  logic [NUM_BANKS*DATA_W-1:0]              sram_dq_i
);

  localparam int BS   = bank_sel_w(NUM_BANKS);
  localparam int BE_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(WRITE_WIDTH - 1);
  localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(WRITE_RECOVERY - 1);

  if (!cfg_ok(DATA_W, NUM_BANKS, BANK_AW, READ_WAIT, WRITE_WIDTH, WRITE_RECOVERY)) begin : g_cfg_check
    $error("sram_bank_ctrl: parameter out of legal range");
  end

  state_t                 state, next_state;
  logic [CNT_W-1:0]       cnt;
  logic [BS-1:0]          in_bank, bank_q, bank_n;
  logic [BANK_AW-1:0]     word_q;
  logic [BE_W-1:0]        be_q;
  logic [DATA_W-1:0]      wbuf_q, rd_sel, merged;
  logic                   rmw_q, err_q, accept, bank_bad, rd_last;
  logic [NUM_BANKS-1:0]   bank_hit, ce_d, dq_oe_d;
  logic                   oe_d, we_d;

  assign in_bank  = addr[BANK_AW+BS-1 -: BS];
  assign bank_bad = int'(in_bank) >= NUM_BANKS;
  assign accept   = (state == ST_IDLE) && req;
  assign rd_last  = (state == ST_RD) && (cnt == RD_LAST);
  assign bank_n   = accept ? in_bank : bank_q;

  assign ack       = (state == ST_DONE);
  assign err       = ack && err_q;
  assign busy      = (state != ST_IDLE);
  assign sram_addr = word_q;
  assign sram_dq_o = {NUM_BANKS{wbuf_q}};

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          if (bank_bad)          next_state = ST_DONE;
          else if (!we)          next_state = ST_RD;
          else if (be == '1)     next_state = ST_WR_SETUP;
          else if (be == '0)     next_state = ST_DONE;
          else                   next_state = ST_RD;
        end
      end
      ST_RD:       if (rd_last) next_state = rmw_q ? ST_WR_SETUP : ST_DONE;
      ST_WR_SETUP: next_state = ST_WR_PULSE;
      ST_WR_PULSE: if (cnt == PULSE_LAST) next_state = (WRITE_RECOVERY == 0) ? ST_DONE : ST_WR_RECOV;
      ST_WR_RECOV: if (cnt == RECOV_LAST) next_state = ST_DONE;
      ST_DONE:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bank_hit = '0;
    rd_sel   = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      bank_hit[k] = (bank_n == BS'(k));
      if (bank_q == BS'(k)) rd_sel = sram_dq_i[k*DATA_W +: DATA_W];
    end
  end

  // Strobes are decoded from the state being entered so the pins leave a flop every cycle.
  always_comb begin
    ce_d    = '1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    dq_oe_d = '0;
    unique case (next_state)
      ST_RD: begin
        ce_d = ~bank_hit;
        oe_d = 1'b0;
      end
      ST_WR_SETUP, ST_WR_RECOV: begin
        ce_d    = ~bank_hit;
        dq_oe_d = bank_hit;
      end
      ST_WR_PULSE: begin
        ce_d    = ~bank_hit;
        dq_oe_d = bank_hit;
        we_d    = 1'b0;
      end
      default: ;
    endcase
  end

  sram_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .rd_word (rd_sel),
    .wr_word (wbuf_q),
    .be      (be_q),
    .merged  (merged)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bank_q     <= '0;
      word_q     <= '0;
      be_q       <= '0;
      wbuf_q     <= '0;
      rmw_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata      <= '0;
      sram_ce_n  <= '1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= '0;
    end else begin
      state <= next_state;
      cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
      if (accept) begin
        bank_q <= in_bank;
        word_q <= addr[BANK_AW-1:0];
        be_q   <= be;
        wbuf_q <= wdata;
        rmw_q  <= we && (be != '0) && (be != '1);
        err_q  <= bank_bad;
      end
      if (rd_last) begin
        if (rmw_q) wbuf_q <= merged;
        else       rdata  <= rd_sel;
      end
      sram_ce_n  <= ce_d;
      sram_oe_n  <= oe_d;
      sram_we_n  <= we_d;
      sram_dq_oe <= dq_oe_d;
    end
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed and random checks of sram_bank_ctrl in its default configuration and in a
// three-bank configuration with longer read wait, wider write pulse and no recovery.
module tb_sram_bank_ctrl;

  logic clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- configuration A: defaults ----------------
  logic        a_rst = 1'b1, a_req = 1'b0, a_we = 1'b0;
  logic [3:0]  a_be = '0;
  logic [20:0] a_addr = '0;
  logic [31:0] a_wdata = '0, a_rdata;
  logic        a_ack, a_err, a_busy, a_oe_n, a_we_n;
  logic [19:0] a_sram_addr;
  logic [1:0]  a_ce_n, a_dq_oe;
  logic [63:0] a_dq_o, a_dq_i = '0;

  sram_bank_ctrl u_dut_a (
    .clk50M(clk50M), .rst(a_rst), .req(a_req), .we(a_we), .be(a_be), .addr(a_addr),
    .wdata(a_wdata), .rdata(a_rdata), .ack(a_ack), .err(a_err), .busy(a_busy),
    .sram_addr(a_sram_addr), .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n),
    .sram_dq_o(a_dq_o), .sram_dq_oe(a_dq_oe), .sram_dq_i(a_dq_i)
  );

  logic [31:0] mem_a [int];
  logic [31:0] ref_a [int];
  int a_cyc = 0, a_viol = 0, a_we_cnt = 0, a_first_we = -1, a_last_oe = -1, a_acks = 0;
  logic [1:0] a_ce_seen = '0;

  function automatic logic [31:0] mem_rd(input int key);
    return mem_a.exists(key) ? mem_a[key] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input int key);
    return ref_a.exists(key) ? ref_a[key] : 32'h0;
  endfunction

  function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Behavioural SRAM pair plus invariant monitor, sampled mid-cycle.
  always @(negedge clk50M) begin
    a_cyc++;
    if (!a_oe_n && !a_we_n) a_viol++;
    if ((a_dq_oe != 2'b00) && !a_oe_n) a_viol++;
    if ($countones(~a_ce_n) > 1) a_viol++;
    if (!a_we_n) begin
      a_we_cnt++;
      if (a_first_we < 0) a_first_we = a_cyc;
    end
    if (!a_oe_n) a_last_oe = a_cyc;
    a_ce_seen = a_ce_seen | ~a_ce_n;
    if (a_ack) a_acks++;
    for (int k = 0; k < 2; k++) begin
      if (!a_we_n && !a_ce_n[k] && a_dq_oe[k])
        mem_a[k * (1 << 20) + int'(a_sram_addr)] = a_dq_o[k*32 +: 32];
      a_dq_i[k*32 +: 32] = (!a_ce_n[k] && !a_oe_n) ? mem_rd(k * (1 << 20) + int'(a_sram_addr))
                                                   : 32'h0;
    end
  end

  task automatic txn_a(input logic w, input logic [3:0] b, input logic [20:0] ad,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic e);
    a_we_cnt = 0; a_first_we = -1; a_last_oe = -1; a_ce_seen = '0; a_acks = 0;
    a_req = 1'b1; a_we = w; a_be = b; a_addr = ad; a_wdata = d;
    @(posedge clk50M); #1;
    a_req = 1'b0;
    lat = 1;
    while (!a_ack && lat < 60) begin
      @(posedge clk50M); #1;
      lat++;
    end
    if (!a_ack) check("a_ack_timeout", a_ack, 1'b1);
    rd = a_rdata;
    e  = a_err;
    @(posedge clk50M); #1;
  endtask

  // ---------------- configuration B: 3 banks, RW=2, WW=3, WR=0 ----------------
  logic        b_rst = 1'b1, b_req = 1'b0, b_we = 1'b0;
  logic [3:0]  b_be = '0;
  logic [21:0] b_addr = '0;
  logic [31:0] b_wdata = '0, b_rdata;
  logic        b_ack, b_err, b_busy, b_oe_n, b_we_n;
  logic [19:0] b_sram_addr;
  logic [2:0]  b_ce_n, b_dq_oe;
  logic [95:0] b_dq_o;
  logic [95:0] b_dq_i = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};

  sram_bank_ctrl #(.NUM_BANKS(3), .READ_WAIT(2), .WRITE_WIDTH(3), .WRITE_RECOVERY(0)) u_dut_b (
    .clk50M(clk50M), .rst(b_rst), .req(b_req), .we(b_we), .be(b_be), .addr(b_addr),
    .wdata(b_wdata), .rdata(b_rdata), .ack(b_ack), .err(b_err), .busy(b_busy),
    .sram_addr(b_sram_addr), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n),
    .sram_dq_o(b_dq_o), .sram_dq_oe(b_dq_oe), .sram_dq_i(b_dq_i)
  );

  int b_viol = 0, b_we_cnt = 0;
  logic [2:0]  b_ce_seen = '0;
  logic [31:0] b_last_wdata = '0;

  always @(negedge clk50M) begin
    if (!b_oe_n && !b_we_n) b_viol++;
    if ((b_dq_oe != 3'b000) && !b_oe_n) b_viol++;
    if ($countones(~b_ce_n) > 1) b_viol++;
    if (!b_we_n) b_we_cnt++;
    b_ce_seen = b_ce_seen | ~b_ce_n;
    for (int k = 0; k < 3; k++)
      if (!b_we_n && !b_ce_n[k] && b_dq_oe[k]) b_last_wdata = b_dq_o[k*32 +: 32];
  end

  task automatic txn_b(input logic w, input logic [3:0] b, input logic [21:0] ad,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic e);
    b_we_cnt = 0; b_ce_seen = '0;
    b_req = 1'b1; b_we = w; b_be = b; b_addr = ad; b_wdata = d;
    @(posedge clk50M); #1;
    b_req = 1'b0;
    lat = 1;
    while (!b_ack && lat < 60) begin
      @(posedge clk50M); #1;
      lat++;
    end
    if (!b_ack) check("b_ack_timeout", b_ack, 1'b1);
    rd = b_rdata;
    e  = b_err;
    @(posedge clk50M); #1;
  endtask

  // ---------------- stimulus ----------------
  int          lat, rkey;
  logic [31:0] rd, rdat, exp_val;
  logic        e, rw;
  logic [3:0]  rbe;
  logic [20:0] raddr;

  initial begin
    repeat (2) @(posedge clk50M);
    #1;
    check("rst_ack",   a_ack, 1'b0);
    check("rst_err",   a_err, 1'b0);
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_busy",  a_busy, 1'b0);
    check("rst_ce_n",  a_ce_n, 2'b11);
    check("rst_oe_we", {a_oe_n, a_we_n}, 2'b11);
    check("rst_dq_oe", a_dq_oe, 2'b00);
    check("rst_addr",  a_sram_addr, 20'h0);
    check("rst_b_ce_n", b_ce_n, 3'b111);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(posedge clk50M); #1;

    // Full write then read, bank 0.
    txn_a(1'b1, 4'hF, 21'h00010, 32'hDEADBEEF, lat, rd, e);
    check("wr_latency", lat, 4);
    check("wr_we_cycles", a_we_cnt, 1);
    check("wr_ce_bank0", a_ce_seen, 2'b01);
    check("wr_mem", mem_rd(32'h10), 32'hDEADBEEF);
    check("wr_one_ack", a_acks, 1);
    check("wr_err", e, 1'b0);
    txn_a(1'b0, 4'h0, 21'h00010, 32'h0, lat, rd, e);
    check("rd_latency", lat, 2);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_no_we", a_we_cnt, 0);

    // Bank 1.
    txn_a(1'b1, 4'hF, 21'h100004, 32'hCAFEF00D, lat, rd, e);
    check("b1_wr_ce", a_ce_seen, 2'b10);
    check("b1_wr_latency", lat, 4);
    txn_a(1'b0, 4'h0, 21'h100004, 32'h0, lat, rd, e);
    check("b1_rd_ce", a_ce_seen, 2'b10);
    check("b1_rd_data", rd, 32'hCAFEF00D);
    check("b1_bank0_untouched", mem_a.exists(32'h4), 0);
    check("b1_bank0_keep", mem_rd(32'h10), 32'hDEADBEEF);

    // Read-modify-write.
    txn_a(1'b1, 4'hF, 21'h00020, 32'h11223344, lat, rd, e);
    txn_a(1'b1, 4'b0101, 21'h00020, 32'hAABBCCDD, lat, rd, e);
    check("rmw_latency", lat, 5);
    check("rmw_mem", mem_rd(32'h20), 32'h11BB33DD);
    check("rmw_oe_before_we", (a_last_oe > 0) && (a_last_oe < a_first_we), 1'b1);
    check("rmw_we_cycles", a_we_cnt, 1);
    check("rmw_rdata_hold", rd, 32'hCAFEF00D);
    txn_a(1'b0, 4'h0, 21'h00020, 32'h0, lat, rd, e);
    check("rmw_readback", rd, 32'h11BB33DD);

    // be=0 write: no pin activity, single-cycle ack.
    txn_a(1'b1, 4'h0, 21'h00020, 32'hFFFFFFFF, lat, rd, e);
    check("be0_latency", lat, 1);
    check("be0_no_ce", a_ce_seen, 2'b00);
    check("be0_mem", mem_rd(32'h20), 32'h11BB33DD);

    // Reset in the middle of the write pulse.
    a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 21'h00030; a_wdata = 32'h55AA55AA;
    @(posedge clk50M); #1;
    a_req = 1'b0;
    @(posedge clk50M); #1;
    check("pre_rst_we_low", a_we_n, 1'b0);
    a_rst = 1'b1;
    @(posedge clk50M); #1;
    check("mid_rst_we_n", a_we_n, 1'b1);
    check("mid_rst_dq_oe", a_dq_oe, 2'b00);
    check("mid_rst_busy", a_busy, 1'b0);
    check("mid_rst_ce_n", a_ce_n, 2'b11);
    a_rst = 1'b0;
    a_acks = 0;
    repeat (4) @(posedge clk50M);
    #1;
    check("mid_rst_no_ack", a_acks, 0);

    // A request arriving while busy is dropped.
    a_acks = 0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 21'h00010;
    @(posedge clk50M); #1;
    a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 21'h00040; a_wdata = 32'h12345678;
    @(posedge clk50M); #1;
    a_req = 1'b0;
    repeat (8) @(posedge clk50M);
    #1;
    check("busy_one_ack", a_acks, 1);
    check("busy_write_dropped", mem_a.exists(32'h40), 0);
    check("busy_read_data", a_rdata, 32'hDEADBEEF);

    // Random traffic on a fresh address window.
    for (int i = 0; i < 40; i++) begin
      raddr = {1'($urandom_range(0, 1)), 20'h00100 + 20'($urandom_range(0, 7))};
      rkey  = int'(raddr[20]) * (1 << 20) + int'(raddr[19:0]);
      rw    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rbe = 4'h0;
        1:       rbe = 4'hF;
        default: rbe = 4'($urandom_range(1, 14));
      endcase
      rdat = $urandom;
      txn_a(rw, rbe, raddr, rdat, lat, rd, e);
      if (rw) begin
        exp_val = merge_ref(ref_rd(rkey), rdat, rbe);
        ref_a[rkey] = exp_val;
        check("rnd_wr_latency", lat, (rbe == 4'h0) ? 1 : (rbe == 4'hF) ? 4 : 5);
        check("rnd_wr_mem", mem_rd(rkey), exp_val);
        if (rbe == 4'h0) check("rnd_be0_no_ce", a_ce_seen, 2'b00);
      end else begin
        check("rnd_rd_latency", lat, 2);
        check("rnd_rd_data", rd, ref_rd(rkey));
      end
    end
    check("a_invariants", a_viol, 0);

    // Configuration B.
    txn_b(1'b0, 4'h0, {2'd3, 20'h00010}, 32'h0, lat, rd, e);
    check("b_err_latency", lat, 1);
    check("b_err_flag", e, 1'b1);
    check("b_err_no_ce", b_ce_seen, 3'b000);
    txn_b(1'b0, 4'h0, {2'd1, 20'h00020}, 32'h0, lat, rd, e);
    check("b_rd_latency", lat, 4);
    check("b_rd_err", e, 1'b0);
    check("b_rd_data_bank1", rd, 32'hB1B1B1B1);
    check("b_rd_ce", b_ce_seen, 3'b010);
    txn_b(1'b0, 4'h0, {2'd2, 20'h00020}, 32'h0, lat, rd, e);
    check("b_rd_data_bank2", rd, 32'hC2C2C2C2);
    txn_b(1'b1, 4'hF, {2'd2, 20'h00008}, 32'h0F1E2D3C, lat, rd, e);
    check("b_wr_latency", lat, 5);
    check("b_wr_we_cycles", b_we_cnt, 3);
    check("b_wr_ce", b_ce_seen, 3'b100);
    check("b_wr_data", b_last_wdata, 32'h0F1E2D3C);
    txn_b(1'b1, 4'b0011, {2'd0, 20'h00008}, 32'h12345678, lat, rd, e);
    check("b_rmw_latency", lat, 8);
    check("b_rmw_data", b_last_wdata, 32'hA0A05678);
    check("b_invariants", b_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
